deadtime_insert: RTL and testbench
==================================

DEADTIME_INSERT -- requirements
Module: deadtime_insert

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 8, the width of deadtime_i and the internal dead-time counter.
REQ-002 SHALL have port clk_i, input, 1, the single clock, the same domain as the upstream symmetrical PWM.
REQ-003 SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port enable_i, input, 1, the output enable (registered PWM enable).
REQ-005 SHALL have port tz_i, input, 1, a trip-zone fault request, active-high.
REQ-006 SHALL have port fault_clr_i, input, 1, which clears the latched fault.
REQ-007 SHALL have port PWM_i, input, 1, the reference PWM from the symmetrical PWM stage.
REQ-008 SHALL have port deadtime_i, input, DT_WIDTH, the dead interval in clk_i cycles.
REQ-009 SHALL have port PWM_H_o, output, 1, the high-side gate command.
REQ-010 SHALL have port PWM_L_o, output, 1, the low-side gate command.
REQ-011 SHALL have port dead_o, output, 1, asserted during any dead interval.
REQ-012 SHALL have port fault_o, output, 1, the sticky fault flag.

Function
REQ-013 SHALL implement the states IDLE, DT_H, ON_H, DT_L and ON_L; all outputs are driven from registers, with no combinational path from input to output.
REQ-014 SHALL drive the outputs by state as follows: IDLE H=0 L=0 dead=0; DT_H and DT_L H=0 L=0 dead=1; ON_H H=1 L=0; ON_L H=0 L=1.
REQ-015 SHALL never assert PWM_H_o and PWM_L_o in the same cycle, under any input sequence.
REQ-016 SHALL, on any edge while in IDLE with enable_i=1 and fault_o=0, load cnt<=deadtime_i-1 and move to DT_H if PWM_i=1, else to DT_L.
REQ-017 SHALL, on an edge in ON_H with PWM_i=0, move to DT_L with cnt<=deadtime_i-1.
REQ-018 SHALL, on an edge in ON_L with PWM_i=1, move to DT_H with cnt<=deadtime_i-1.
REQ-019 SHALL, on each edge in DT_H or DT_L with cnt!=0, decrement cnt.
REQ-020 SHALL, on an edge in DT_H or DT_L with cnt==0, move to ON_H if PWM_i=1, else to ON_L; the destination is taken from PWM_i at expiry, not at entry.
REQ-021 SHALL give every dead interval a length of exactly deadtime_i cycles, where deadtime_i is sampled only on the entry edge; changes to deadtime_i mid-interval SHALL have no effect.
REQ-022 SHALL treat deadtime_i=0 as a direct switch: ON_H goes to ON_L, ON_L to ON_H, and IDLE to ON per PWM_i, in one edge with no DT state and dead_o staying 0.
REQ-023 SHALL absorb a PWM_i edge that reverses direction during a dead interval: no counter reload, and the interval completes and then follows REQ-020.
REQ-024 SHALL, on any edge with enable_i=0 and in any state, move to IDLE, so the outputs are low on the next cycle.
REQ-025 SHALL, on any edge with tz_i=1, set fault_o<=1 and move to IDLE.
REQ-026 SHALL make tz_i take priority over enable_i and over fault_clr_i in the same cycle.
REQ-027 SHALL keep the block in IDLE while fault_o=1, regardless of enable_i.
REQ-028 SHALL clear fault_o on an edge with fault_clr_i=1 and tz_i=0.
REQ-029 SHALL allow restart to follow REQ-016 no earlier than the edge after fault_o clears.
REQ-030 SHALL apply priority per edge in the order rst_i, tz_i, enable_i=0, then normal transitions.

Reset
REQ-031 SHALL, on an edge with rst_i=1, set state=IDLE, cnt=0, PWM_H_o=0, PWM_L_o=0, dead_o=0 and fault_o=0.
REQ-032 SHALL apply reset mid dead interval or mid ON state immediately on the reset edge, with no completion of the interval.
REQ-033 SHALL, after rst_i deasserts, start only via REQ-016.

Verification
REQ-034 SHALL cover basic switching: deadtime_i=10, enable_i=1, PWM_i toggled every 100 cycles. Required response: H/L both low for exactly 10 cycles after each PWM_i edge, the correct side high afterwards, and never both high.
REQ-035 SHALL cover a glitch inside the dead interval: deadtime_i=10, PWM_i 1->0 then 0->1 four cycles later, from ON_H. Required response: 10 dead cycles, then ON_H, with no extra dead interval.
REQ-036 SHALL cover zero dead time: deadtime_i=0 with toggling PWM_i. Required response: ON_H and ON_L alternate directly, dead_o=0 throughout, and H and L are never both high.
REQ-037 SHALL cover a trip during operation: tz_i pulsed 1 cycle in ON_H. Required response: H=L=0 next cycle, fault_o=1, and no restart while enable_i=1. Then fault_clr_i pulsed: fault_o=0, followed by deadtime_i dead cycles and the ON state per PWM_i.
REQ-038 SHALL cover enable and reset mid-interval: enable_i dropped at dead count 3 of 10, giving IDLE next cycle. Re-enabling SHALL give a full 10-cycle dead interval. rst_i asserted in DT_L SHALL give all outputs 0 the next cycle.
REQ-039 SHALL cover simultaneous events: tz_i=1 with fault_clr_i=1 in the same cycle. Required response: fault_o stays 1.

Source files
------------

// File: rtl/deadtime_insert.sv
// Dead-time insertion for a half bridge.
// Splits one reference PWM into complementary high/low gate commands.
// A dead interval is inserted at every switch-over so that both gates are never on together.
// A trip-zone input latches a sticky fault that holds both gates off until it is cleared.
//
// Handshake: there is none. All inputs are sampled on every rising edge of clk_i.
// Every output comes straight from a flop, so there is no path from an input to an output.
module deadtime_insert #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                tz_i,
  input  logic                fault_clr_i,
  input  logic                PWM_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  output logic                PWM_H_o,
  output logic                PWM_L_o,
  output logic                dead_o,
  output logic                fault_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DT_H = 3'd1,
    ON_H = 3'd2,
    DT_L = 3'd3,
    ON_L = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic                h_q, h_d;
  logic                l_q, l_d;
  logic                dead_q, dead_d;

  logic                dt_zero;
  logic [DT_WIDTH-1:0] dt_m1;

  assign dt_zero = (deadtime_i == '0);
  assign dt_m1   = deadtime_i - DT_WIDTH'(1);

  // Next state, counter and fault.
  // Priority is trip, then disable or held fault, then normal switching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (tz_i) begin
      fault_d = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (fault_clr_i) fault_d = 1'b0;
      // Gating uses the registered fault.
      // A restart therefore happens no earlier than the edge after the fault clears.
      if (!enable_i || fault_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (dt_zero) state_d = PWM_i ? ON_H : ON_L;
            else begin
              state_d = PWM_i ? DT_H : DT_L;
              cnt_d   = dt_m1;
            end
          end
          ON_H: begin
            if (!PWM_i) begin
              if (dt_zero) state_d = ON_L;
              else begin
                state_d = DT_L;
                cnt_d   = dt_m1;
              end
            end
          end
          ON_L: begin
            if (PWM_i) begin
              if (dt_zero) state_d = ON_H;
              else begin
                state_d = DT_H;
                cnt_d   = dt_m1;
              end
            end
          end
          DT_H, DT_L: begin
            // The destination is taken from PWM_i at expiry.
            // A reversed PWM edge during the interval is absorbed without reloading the counter.
            if (cnt_q != '0) cnt_d = cnt_q - DT_WIDTH'(1);
            else state_d = PWM_i ? ON_H : ON_L;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Gate outputs are decoded from the next state and registered.
  // They therefore always match the current state one-for-one.
  always_comb begin
    h_d    = (state_d == ON_H);
    l_d    = (state_d == ON_L);
    dead_d = (state_d == DT_H) || (state_d == DT_L);
  end

  // State, counter, fault and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      h_q     <= h_d;
      l_q     <= l_d;
      dead_q  <= dead_d;
    end
  end

  assign PWM_H_o = h_q;
  assign PWM_L_o = l_q;
  assign dead_o  = dead_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_deadtime_insert.sv
// Self-checking bench for deadtime_insert.
// The reference model tracks "active side" and "dead cycles remaining" as plain integers.
module tb_deadtime_insert;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       tz = 1'b0;
  logic       fclr = 1'b0;
  logic       pwm = 1'b0;
  logic [7:0] dt = 8'd0;
  logic       h_o, l_o, dead_o, fault_o;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_active;  // gates are being driven (not idle)
  bit m_side;    // 1 = high side owns the bridge, 0 = low side
  int m_dl;      // dead cycles still to be shown, 0 when not dead
  bit m_fault;

  deadtime_insert #(.DT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .tz_i(tz), .fault_clr_i(fclr),
    .PWM_i(pwm), .deadtime_i(dt),
    .PWM_H_o(h_o), .PWM_L_o(l_o), .dead_o(dead_o), .fault_o(fault_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference behaviour for one clock edge.
  // It uses the inputs as they are sampled at that edge.
  function automatic void model_step();
    bit old_fault;
    old_fault = m_fault;
    if (rst) begin
      m_active = 0; m_dl = 0; m_fault = 0;
    end else if (tz) begin
      m_active = 0; m_dl = 0; m_fault = 1;
    end else begin
      if (fclr) m_fault = 0;
      if (!en || old_fault) begin
        m_active = 0; m_dl = 0;
      end else if (m_dl > 0) begin
        m_dl = m_dl - 1;
        if (m_dl == 0) m_side = pwm;
      end else if (!m_active || m_side != pwm) begin
        m_active = 1;
        if (dt == 0) m_side = pwm;
        else m_dl = int'(dt);
      end
    end
  endfunction

  function automatic logic [3:0] exp_out();
    exp_out = {m_active && m_dl == 0 && m_side,
               m_active && m_dl == 0 && !m_side,
               m_active && m_dl > 0,
               m_fault};
  endfunction

  // Driver: advance one edge and let the outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; pwm = 1; dt = 8'd3;
    tick(); tick();
    tests++;
    if ({h_o, l_o, dead_o, fault_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs got=%b exp=0000", {h_o, l_o, dead_o, fault_o});
    end
    rst = 0; en = 0;
    tick();
    tests++;
    if ({h_o, l_o, dead_o, fault_o} !== 4'b0000) begin
      fails++; $display("FAIL idle_after_reset got=%b exp=0000", {h_o, l_o, dead_o, fault_o});
    end
  endtask

  task automatic test_basic();
    int run;
    int bad_len;
    run = 0; bad_len = 0;
    dt = 8'd10; en = 1; pwm = 1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0 && i % 100 == 0) pwm = ~pwm;
      tick();
      tests++;
      if ({h_o, l_o, dead_o, fault_o} !== exp_out() || (h_o && l_o)) begin
        fails++; $display("FAIL basic_cycle%0d got=%b exp=%b", i, {h_o, l_o, dead_o, fault_o}, exp_out());
      end
      if (dead_o) run++;
      else if (run != 0) begin
        if (run != 10) bad_len++;
        run = 0;
      end
    end
    tests++;
    if (bad_len != 0) begin
      fails++; $display("FAIL basic_dead_len bad_intervals=%0d exp=0", bad_len);
    end
    tests++;
    if (l_o !== 1'b1) begin
      fails++; $display("FAIL basic_final_side got_L=%b exp=1", l_o);
    end
  endtask

  task automatic test_glitch();
    int dead_cnt;
    dead_cnt = 0;
    dt = 8'd10; en = 1; pwm = 1;
    for (int i = 0; i < 30; i++) tick();
    pwm = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 3) pwm = 1;
      if (dead_o) dead_cnt++;
      tests++;
      if ({h_o, l_o, dead_o, fault_o} !== exp_out()) begin
        fails++; $display("FAIL glitch_cycle%0d got=%b exp=%b", i, {h_o, l_o, dead_o, fault_o}, exp_out());
      end
    end
    tests++;
    if (dead_cnt != 10 || h_o !== 1'b1) begin
      fails++; $display("FAIL glitch_result dead=%0d H=%b exp dead=10 H=1", dead_cnt, h_o);
    end
  endtask

  task automatic test_zero_dt();
    int toggles;
    toggles = 0;
    dt = 8'd0; en = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin pwm = ~pwm; toggles++; end
      tick();
      tests++;
      if (dead_o !== 1'b0 || (h_o && l_o) || {h_o, l_o, dead_o, fault_o} !== exp_out()) begin
        fails++; $display("FAIL zero_dt_cycle%0d got=%b exp=%b", i, {h_o, l_o, dead_o, fault_o}, exp_out());
      end
      tests++;
      if (h_o !== pwm || l_o !== ~pwm) begin
        fails++; $display("FAIL zero_dt_follow%0d H=%b L=%b pwm=%b", i, h_o, l_o, pwm);
      end
    end
  endtask

  task automatic test_trip();
    int dead_cnt;
    dead_cnt = 0;
    dt = 8'd10; en = 1; pwm = 1;
    for (int i = 0; i < 30; i++) tick();
    tests++;
    if (h_o !== 1'b1) begin
      fails++; $display("FAIL trip_pre_on_h got=%b exp=1", h_o);
    end
    tz = 1; tick(); tz = 0;
    tests++;
    if ({h_o, l_o, dead_o, fault_o} !== 4'b0001) begin
      fails++; $display("FAIL trip_response got=%b exp=0001", {h_o, l_o, dead_o, fault_o});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({h_o, l_o, dead_o, fault_o} !== 4'b0001) begin
        fails++; $display("FAIL trip_hold%0d got=%b exp=0001", i, {h_o, l_o, dead_o, fault_o});
      end
    end
    fclr = 1; tick(); fclr = 0;
    tests++;
    if ({h_o, l_o, dead_o, fault_o} !== 4'b0000) begin
      fails++; $display("FAIL trip_clear got=%b exp=0000", {h_o, l_o, dead_o, fault_o});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dead_o) dead_cnt++;
      tests++;
      if ({h_o, l_o, dead_o, fault_o} !== exp_out()) begin
        fails++; $display("FAIL trip_restart%0d got=%b exp=%b", i, {h_o, l_o, dead_o, fault_o}, exp_out());
      end
    end
    tests++;
    if (dead_cnt != 10 || h_o !== 1'b1) begin
      fails++; $display("FAIL trip_restart_result dead=%0d H=%b exp dead=10 H=1", dead_cnt, h_o);
    end
  endtask

  task automatic test_enable_reset();
    int dead_cnt;
    dead_cnt = 0;
    dt = 8'd10; en = 1; pwm = 1;
    for (int i = 0; i < 30; i++) tick();
    pwm = 0;
    tick(); tick(); tick();
    en = 0; tick();
    tests++;
    if ({h_o, l_o, dead_o, fault_o} !== 4'b0000) begin
      fails++; $display("FAIL disable_mid_dt got=%b exp=0000", {h_o, l_o, dead_o, fault_o});
    end
    en = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dead_o) dead_cnt++;
    end
    tests++;
    if (dead_cnt != 10 || l_o !== 1'b1 || {h_o, l_o, dead_o, fault_o} !== exp_out()) begin
      fails++; $display("FAIL reenable_full_dt dead=%0d L=%b exp dead=10 L=1", dead_cnt, l_o);
    end
    pwm = 1;
    for (int i = 0; i < 12; i++) tick();
    pwm = 0; tick(); tick();
    tests++;
    if (dead_o !== 1'b1) begin
      fails++; $display("FAIL in_dt_l got=%b exp=1", dead_o);
    end
    rst = 1; tick(); rst = 0;
    tests++;
    if ({h_o, l_o, dead_o, fault_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_mid_dt got=%b exp=0000", {h_o, l_o, dead_o, fault_o});
    end
  endtask

  task automatic test_simultaneous();
    en = 1; dt = 8'd4;
    tz = 1; tick(); tz = 0;
    tz = 1; fclr = 1; tick(); tz = 0; fclr = 0;
    tests++;
    if (fault_o !== 1'b1 || {h_o, l_o} !== 2'b00) begin
      fails++; $display("FAIL tz_with_clear fault=%b HL=%b exp fault=1 HL=00", fault_o, {h_o, l_o});
    end
    fclr = 1; tick(); fclr = 0;
    tests++;
    if (fault_o !== 1'b0) begin
      fails++; $display("FAIL clear_after got=%b exp=0", fault_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      tz   = ($urandom_range(0, 149) == 0);
      fclr = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 14) == 0) pwm = ~pwm;
      if ($urandom_range(0, 9) == 0) dt = 8'($urandom_range(0, 6));
      tick();
      tests++;
      if ({h_o, l_o, dead_o, fault_o} !== exp_out() || (h_o && l_o)) begin
        fails++; $display("FAIL random_cycle%0d got=%b exp=%b", i, {h_o, l_o, dead_o, fault_o}, exp_out());
      end
    end
    rst = 0; tz = 0; fclr = 0;
  endtask

  initial begin
    m_active = 0; m_side = 0; m_dl = 0; m_fault = 0;
    test_reset();
    test_basic();
    test_glitch();
    test_zero_dt();
    test_trip();
    test_enable_reset();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
